// File: rtl/pa_useq.sv
`default_nettype none
// ============================================================================
//  Module      : pa_useq (package)
//  Description : Shared definitions for the Sol-1 microcode sequencer:
//                sequencing-type encoding, control-word field positions and
//                the micro-address width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pa_useq;

    // Sequencing type carried in the low two bits of every control word
    typedef enum logic [1:0] {
        TYP_OFFSET   = 2'b00,
        TYP_BRANCH   = 2'b01,
        TYP_PREFETCH = 2'b10,
        TYP_FETCH    = 2'b11
    } typ_e;

    // Fixed positions of the sequencing fields inside the control word
    localparam int c_TYP_LSB    = 0;
    localparam int c_OFF_LSB    = 2;
    localparam int c_OFF_W      = 7;
    localparam int c_INV_BIT    = 9;
    localparam int c_SRC_BIT    = 10;
    localparam int c_SEL_LSB    = 11;
    localparam int c_SEL_W      = 4;
    localparam int c_ESC_BIT    = 15;
    localparam int c_FIELDS_W   = 16;

    // Micro-address = {page, opcode, cycle}
    function automatic int uaddr_w(input int page_w, input int opcode_w,
                                   input int cycle_w);
        return page_w + opcode_w + cycle_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/u_cond_mux.sv
`default_nettype none
// ============================================================================
//  Module      : u_cond_mux
//  Description : Selects one of 32 condition bits (16 CPU + 16 micro flags)
//                and optionally inverts it.
//  Ports       : i_cond_cpu  CPU condition vector
//                i_cond_u    micro-flag condition vector
//                i_flag_src  1 selects micro flags, 0 selects CPU flags
//                i_sel       bit index within the chosen vector
//                i_invert    invert the selected bit
//                o_cond      resulting condition
//  Revision    : 1.0  initial release
// ============================================================================
module u_cond_mux (
    input  logic [15:0] i_cond_cpu,
    input  logic [15:0] i_cond_u,
    input  logic        i_flag_src,
    input  logic [3:0]  i_sel,
    input  logic        i_invert,
    output logic        o_cond
);

    logic [31:0] w_vec;

    // Micro flags occupy the upper half so {src, sel} is a direct index
    assign w_vec  = {i_cond_u, i_cond_cpu};
    assign o_cond = w_vec[{i_flag_src, i_sel}] ^ i_invert;

endmodule
`default_nettype wire

// File: rtl/u_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : u_sequencer
//  Description : Microcode sequencer for the Sol-1 control unit. Holds the
//                micro-address register and computes the next address from
//                the sequencing fields of the current control word, with
//                escape opcode pages, interrupt vectoring at the prefetch
//                point, stall hold and a sticky offset-wrap error flag.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                stall           hold all state this cycle
//                u_addr          registered micro-address to the ROM bank
//                u_word          control word read from ROM at u_addr
//                ir              instruction register (dispatch opcode)
//                cond_cpu/cond_u condition vectors
//                int_pending     interrupt request
//                irq_en          interrupt enable
//                int_taken       pulse, high while u_addr first shows vector
//                page            current escape page
//                wrap_err        sticky offset-wrap error
//  Revision    : 1.0  initial release
// ============================================================================
module u_sequencer
    import pa_useq::*;
#(
    parameter int          NUM_UROMS  = 14,
    parameter int          OPCODE_W   = 8,
    parameter int          CYCLE_W    = 6,
    parameter int          PAGE_W     = 1,
    // Opcode whose cycle 0 (page 0) is the interrupt entry point
    parameter int unsigned INT_VECTOR = 'h10,
    localparam int         UADDR_W    = uaddr_w(PAGE_W, OPCODE_W, CYCLE_W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    output logic [UADDR_W-1:0]     u_addr,
    input  logic [8*NUM_UROMS-1:0] u_word,
    input  logic [OPCODE_W-1:0]    ir,
    input  logic [15:0]            cond_cpu,
    input  logic [15:0]            cond_u,
    input  logic                   int_pending,
    input  logic                   irq_en,
    output logic                   int_taken,
    output logic [PAGE_W-1:0]      page,
    output logic                   wrap_err
);

    localparam int c_SUM_W = ((CYCLE_W > c_OFF_W) ? CYCLE_W : c_OFF_W) + 1;

    logic [UADDR_W-1:0]  r_u_addr;
    logic [PAGE_W-1:0]   r_page;
    logic                r_int_taken;
    logic                r_wrap_err;

    typ_e                w_typ;
    logic [c_OFF_W-1:0]  w_offset;
    logic                w_invert;
    logic                w_flag_src;
    logic [c_SEL_W-1:0]  w_sel;
    logic                w_escape;
    logic                w_cond;

    logic [PAGE_W-1:0]   w_pg;
    logic [OPCODE_W-1:0] w_op;
    logic [CYCLE_W-1:0]  w_cyc;
    logic [c_SUM_W-1:0]  w_sum;
    logic                w_carry;
    logic [PAGE_W-1:0]   w_page_inc;

    logic [UADDR_W-1:0]  w_next_addr;
    logic [PAGE_W-1:0]   w_next_page;
    logic                w_set_werr;
    logic                w_take_int;
    logic                w_unused_bits;

    // ---------------- field decode ----------------
    assign w_typ      = typ_e'(u_word[c_TYP_LSB +: 2]);
    assign w_offset   = u_word[c_OFF_LSB +: c_OFF_W];
    assign w_invert   = u_word[c_INV_BIT];
    assign w_flag_src = u_word[c_SRC_BIT];
    assign w_sel      = u_word[c_SEL_LSB +: c_SEL_W];
    assign w_escape   = u_word[c_ESC_BIT];

    // Remaining control-word bits drive datapath elsewhere, not sequencing
    assign w_unused_bits = ^u_word[8*NUM_UROMS-1:c_FIELDS_W];

    u_cond_mux u_cond_mux_i (
        .i_cond_cpu (cond_cpu),
        .i_cond_u   (cond_u),
        .i_flag_src (w_flag_src),
        .i_sel      (w_sel),
        .i_invert   (w_invert),
        .o_cond     (w_cond)
    );

    // ---------------- address arithmetic ----------------
    assign w_pg  = r_u_addr[UADDR_W-1 -: PAGE_W];
    assign w_op  = r_u_addr[CYCLE_W +: OPCODE_W];
    assign w_cyc = r_u_addr[CYCLE_W-1:0];

    // Full 7-bit offset is added; any bit above the cycle field is a wrap
    assign w_sum   = c_SUM_W'(w_cyc) + c_SUM_W'(w_offset);
    assign w_carry = |w_sum[c_SUM_W-1:CYCLE_W];

    // Escape pages saturate at the top page rather than rolling back to 0
    assign w_page_inc = (r_page == {PAGE_W{1'b1}}) ? r_page : r_page + PAGE_W'(1);

    always_comb begin
        w_next_addr = r_u_addr;
        w_next_page = r_page;
        w_set_werr  = 1'b0;
        w_take_int  = 1'b0;
        case (w_typ)
            TYP_OFFSET: begin
                w_next_addr = {w_pg, w_op, w_sum[CYCLE_W-1:0]};
                w_set_werr  = w_carry;
            end
            TYP_BRANCH: begin
                if (w_cond) begin
                    w_next_addr = {w_pg, w_op, CYCLE_W'(w_offset)};
                end else begin
                    w_next_addr = {w_pg, w_op, w_cyc + CYCLE_W'(1)};
                end
            end
            TYP_PREFETCH: begin
                // Interrupt has priority over the normal return to fetch
                if (int_pending && irq_en) begin
                    w_next_addr = {PAGE_W'(0), OPCODE_W'(INT_VECTOR), CYCLE_W'(0)};
                    w_take_int  = 1'b1;
                end else begin
                    w_next_addr = '0;
                end
            end
            TYP_FETCH: begin
                w_next_page = w_escape ? w_page_inc : PAGE_W'(0);
                w_next_addr = {w_next_page, ir, CYCLE_W'(0)};
            end
            default: begin
                w_next_addr = r_u_addr;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_u_addr    <= '0;
            r_page      <= '0;
            r_int_taken <= 1'b0;
            r_wrap_err  <= 1'b0;
        end else if (stall) begin
            r_int_taken <= 1'b0;
        end else begin
            r_u_addr    <= w_next_addr;
            r_page      <= w_next_page;
            r_int_taken <= w_take_int;
            r_wrap_err  <= r_wrap_err | w_set_werr;
        end
    end

    assign u_addr    = r_u_addr;
    assign page      = r_page;
    assign int_taken = r_int_taken;
    assign wrap_err  = r_wrap_err;

endmodule
`default_nettype wire

// File: tb/tb_u_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_u_sequencer
//  Description : Self-checking bench for u_sequencer. Directed steps from the
//                test plan followed by randomized control words, compared
//                against an arithmetic reference model of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_u_sequencer;

    localparam int NUM_UROMS = 14;
    localparam int OPCODE_W  = 8;
    localparam int CYCLE_W   = 6;
    localparam int PAGE_W    = 1;
    localparam int INT_VEC   = 'h10;
    localparam int UADDR_W   = PAGE_W + OPCODE_W + CYCLE_W;
    localparam int WORD_W    = 8 * NUM_UROMS;
    localparam int NCYC      = 1 << CYCLE_W;
    localparam int NOP       = 1 << OPCODE_W;
    localparam int MAXPG     = (1 << PAGE_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall;
    logic [UADDR_W-1:0]  u_addr;
    logic [WORD_W-1:0]   u_word;
    logic [OPCODE_W-1:0] ir;
    logic [15:0]         cond_cpu;
    logic [15:0]         cond_u;
    logic                int_pending;
    logic                irq_en;
    logic                int_taken;
    logic [PAGE_W-1:0]   page;
    logic                wrap_err;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state (plain integers)
    int m_pg, m_op, m_cyc, m_page;
    bit m_werr, m_itk;

    u_sequencer #(
        .NUM_UROMS  (NUM_UROMS),
        .OPCODE_W   (OPCODE_W),
        .CYCLE_W    (CYCLE_W),
        .PAGE_W     (PAGE_W),
        .INT_VECTOR (INT_VEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .u_addr      (u_addr),
        .u_word      (u_word),
        .ir          (ir),
        .cond_cpu    (cond_cpu),
        .cond_u      (cond_u),
        .int_pending (int_pending),
        .irq_en      (irq_en),
        .int_taken   (int_taken),
        .page        (page),
        .wrap_err    (wrap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        int exp_addr;
        exp_addr = m_pg * NOP * NCYC + m_op * NCYC + m_cyc;
        vectors++;
        assert (u_addr === UADDR_W'(exp_addr)) else begin
            miscompares++;
            $error("FAIL %s u_addr: got %h expected %h", tag, u_addr, UADDR_W'(exp_addr));
        end
        vectors++;
        assert (page === PAGE_W'(m_page)) else begin
            miscompares++;
            $error("FAIL %s page: got %h expected %h", tag, page, PAGE_W'(m_page));
        end
        vectors++;
        assert (int_taken === m_itk) else begin
            miscompares++;
            $error("FAIL %s int_taken: got %b expected %b", tag, int_taken, m_itk);
        end
        vectors++;
        assert (wrap_err === m_werr) else begin
            miscompares++;
            $error("FAIL %s wrap_err: got %b expected %b", tag, wrap_err, m_werr);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare
    task automatic step(input string tag, input bit rn, input bit st,
                        input int typ, input int off, input bit inv,
                        input bit src, input int sel, input bit esc,
                        input int irv, input logic [15:0] ccpu,
                        input logic [15:0] cu, input bit ip, input bit ie);
        logic [WORD_W-1:0] w;
        bit c;
        int s, np;
        for (int k = 0; k < WORD_W; k++) w[k] = 1'($urandom_range(0, 1));
        w[1:0]   = 2'(typ);
        w[8:2]   = 7'(off);
        w[9]     = inv;
        w[10]    = src;
        w[14:11] = 4'(sel);
        w[15]    = esc;
        rst_n = rn; stall = st; u_word = w; ir = OPCODE_W'(irv);
        cond_cpu = ccpu; cond_u = cu; int_pending = ip; irq_en = ie;

        if (!rn) begin
            m_pg = 0; m_op = 0; m_cyc = 0; m_page = 0; m_werr = 0; m_itk = 0;
        end else if (st) begin
            m_itk = 0;
        end else begin
            m_itk = 0;
            case (typ)
                0: begin
                    s = m_cyc + off;
                    if (s >= NCYC) m_werr = 1;
                    m_cyc = s % NCYC;
                end
                1: begin
                    c = (src ? cu[sel] : ccpu[sel]) ^ inv;
                    m_cyc = c ? (off % NCYC) : ((m_cyc + 1) % NCYC);
                end
                2: begin
                    if (ip && ie) begin
                        m_pg = 0; m_op = INT_VEC; m_cyc = 0; m_itk = 1;
                    end else begin
                        m_pg = 0; m_op = 0; m_cyc = 0;
                    end
                end
                default: begin
                    np = esc ? ((m_page >= MAXPG) ? MAXPG : m_page + 1) : 0;
                    m_page = np; m_pg = np; m_op = irv % NOP; m_cyc = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        m_pg = 0; m_op = 0; m_cyc = 0; m_page = 0; m_werr = 0; m_itk = 0;
        rst_n = 1'b0; stall = 1'b0; u_word = '0; ir = '0;
        cond_cpu = '0; cond_u = '0; int_pending = 1'b0; irq_en = 1'b0;

        // Reset
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        // FETCH ir=0x3A
        step("fetch3A", 1, 0, 3, 0, 0, 0, 0, 0, 'h3A, 16'h0, 16'h0, 0, 0);
        // OFFSET to cyc 5, then +3 -> 8
        step("off5", 1, 0, 0, 5, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("off3", 1, 0, 0, 3, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        // reach 62, then +4 wraps to 2 and sets wrap_err
        step("off54", 1, 0, 0, 54, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("wrap", 1, 0, 0, 4, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("sticky", 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        // BRANCH taken / not taken via invert
        step("br_take", 1, 0, 1, 20, 0, 0, 2, 0, 0, 16'h0004, 16'h0, 0, 0);
        step("br_inv", 1, 0, 1, 20, 1, 0, 2, 0, 0, 16'h0004, 16'h0, 0, 0);
        step("br_usrc", 1, 0, 1, 9, 0, 1, 15, 0, 0, 16'h0, 16'h8000, 0, 0);
        // Escape page and return to page 0
        step("fetch_esc", 1, 0, 3, 0, 0, 0, 0, 1, 'h07, 16'h0, 16'h0, 0, 0);
        step("esc_sat", 1, 0, 3, 0, 0, 0, 0, 1, 'h08, 16'h0, 16'h0, 0, 0);
        step("off_pg1", 1, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("fetch_p0", 1, 0, 3, 0, 0, 0, 0, 0, 'h07, 16'h0, 16'h0, 0, 0);
        // Interrupt at PREFETCH, escape set too: interrupt wins
        step("int", 1, 0, 2, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 1, 1);
        step("int_pulse", 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1, 1);
        step("noirq", 1, 0, 2, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1, 0);
        // Stall for 3 cycles, including a stalled PREFETCH with interrupt
        step("off7", 1, 0, 0, 7, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("stall1", 1, 1, 0, 7, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("stall2", 1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1, 1);
        step("stall3", 1, 1, 0, 60, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        step("rst_stall", 0, 1, 0, 7, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

        // Randomized control words
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(0, 59) != 0,
                 $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)),
                 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/u_sequencer.md
# u_sequencer

Parametrised microcode sequencer for the Sol-1 control unit. Holds the microcode address register, decodes the sequencing fields of the current control word (typ, offset, condition select, escape) and computes the next micro-address. Adds escape opcode pages, interrupt vectoring at the prefetch point, stall hold and an offset-wrap error flag. Sits between the instruction register / flag logic and the asynchronous microcode ROM bank.

## Interface
- NUM_UROMS, 14: number of 8-bit microcode ROMs; control word width = 8*NUM_UROMS.
- OPCODE_W, 8: opcode width (IR bits used for dispatch).
- CYCLE_W, 6: micro-cycle field width (cycles per routine = 2^CYCLE_W).
- PAGE_W, 1: escape page bits; UADDR_W = PAGE_W+OPCODE_W+CYCLE_W (derived, localparam).
- INT_VECTOR, 'h10 (cycle 0 of opcode 0x10, page 0): micro-address entered on interrupt.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold all state this cycle (memory wait).
- u_addr  out  UADDR_W  registered micro-address driving the ROM bank.
- u_word  in  8*NUM_UROMS  control word read combinationally from ROM at u_addr.
- ir  in  OPCODE_W  current instruction register.
- cond_cpu  in  16  CPU condition vector (prepared by flag logic).
- cond_u  in  16  micro-flag condition vector.
- int_pending  in  1  interrupt request from interrupt controller.
- irq_en  in  1  status irq enable.
- int_taken  out  1  one-cycle pulse when interrupt vector entered.
- page  out  PAGE_W  current escape page.
- wrap_err  out  1  sticky offset-wrap error.

## Operation
- Fields taken from u_word at fixed positions: typ[1:0] bits 1:0, offset[6:0] bits 8:2, cond_invert bit 9, cond_flag_src bit 10, cond_sel[3:0] bits 14:11, escape bit 15.
- cond = (cond_flag_src ? cond_u : cond_cpu)[cond_sel] XOR cond_invert.
- u_addr split as {pg, op, cyc}. Next address by typ:
  - 00 OFFSET: {pg, op, (cyc + offset) mod 2^CYCLE_W}; if the sum carries out of CYCLE_W bits, wrap_err sets.
  - 01 BRANCH: cond ? {pg, op, offset[CYCLE_W-1:0]} : {pg, op, cyc+1 mod 2^CYCLE_W}.
  - 10 PREFETCH: (int_pending & irq_en) ? INT_VECTOR with int_taken=1 : 0 (fetch routine).
  - 11 FETCH: {page_next, ir, 0}; page_next = escape ? page+1 (saturating at max) : 0.
- page register updates only on typ FETCH; page output always equals pg field of u_addr after the FETCH transfer.
- stall=1: u_addr, page, wrap_err hold; int_taken forced 0; fields ignored.
- wrap_err cleared only by reset.

## Timing
- Reset (rst_n=0 at clk edge): u_addr=0, page=0, int_taken=0, wrap_err=0; takes priority over stall.
- u_addr updates on every rising clk edge with stall=0; ROM path combinational, so one micro-instruction per cycle, zero sequencing latency.
- int_taken registered: high exactly the cycle u_addr = INT_VECTOR first appears.
- Simultaneous int_pending and escape on PREFETCH word: interrupt wins; escape only meaningful on FETCH.
- int_pending sampled only on unstalled PREFETCH cycles; no internal latching.
- Reset mid-routine: next cycle u_addr=0 regardless of typ.

## Structure
- Package pa_useq: typ enum (OFFSET, BRANCH, PREFETCH, FETCH), field bit positions, UADDR_W function of parameters.
- Optional sub-module u_cond_mux (32:1 select + invert); next-address logic and registers in u_sequencer.

## Test plan
- Reset then FETCH word with ir=0x3A, escape=0 -> u_addr={0,0x3A,0}, page=0.
- OFFSET word, cyc=5, offset=3 -> cyc=8, wrap_err=0; cyc=62, offset=4 -> cyc=2, wrap_err=1 and stays 1.
- BRANCH cond_sel=2, cond_flag_src=0, cond_cpu[2]=1, invert=0, offset=20 -> cyc=20; same with invert=1 -> cyc=cyc+1.
- FETCH with escape=1, ir=0x07 -> page=1, u_addr={1,0x07,0}; following FETCH escape=0 -> page=0.
- PREFETCH with int_pending=1, irq_en=1 -> u_addr=INT_VECTOR, int_taken one-cycle pulse; irq_en=0 -> u_addr=0, no pulse.
- stall held 3 cycles on OFFSET word -> u_addr unchanged; rst_n=0 during stall -> u_addr=0 next cycle.
